// File: rtl/mul16_pkg.sv
// Shared types and sizes for the 16-bit shift-add multiplier datapath.
// The offset width is also used by the window extractor.
package mul16_pkg;

    localparam int PART_W   = 16;
    localparam int ACC_W    = 32;
    localparam int N_STEPS  = 16;
    localparam int OFFSET_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/overlap_adder_16x16.sv
// Combinational shifted add: sum = acc + (part << step), modulo 2^ACC_W.
// The shifted operand is zero above bit 15+step.
module overlap_adder_16x16
    import mul16_pkg::*;
(
    input  logic [ACC_W-1:0]    acc,
    input  logic [PART_W-1:0]   part,
    input  logic [OFFSET_W-1:0] step,
    output logic [ACC_W-1:0]    sum
);

    logic [ACC_W-1:0] shifted_s;

    assign shifted_s = {{(ACC_W - PART_W){1'b0}}, part} << step;
    assign sum       = acc + shifted_s;

endmodule

// File: rtl/overlap_accumulator_16x16.sv
// Sequential accumulator: sixteen partial words, word k added at bit offset k.
// All outputs come straight from registers.
module overlap_accumulator_16x16 #(
    parameter int N_STEPS = 16,
    parameter int PART_W  = 16,
    parameter int ACC_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       part_valid,
    input  logic [PART_W-1:0]          part_data,
    output logic                       part_ready,
    output logic [$clog2(N_STEPS)-1:0] step,
    output logic [ACC_W-1:0]           acc,
    output logic                       done,
    input  logic                       done_ack
);

    import mul16_pkg::acc_state_t;
    import mul16_pkg::IDLE;
    import mul16_pkg::ACCUM;
    import mul16_pkg::DONE;

    localparam int                CNT_W     = $clog2(N_STEPS);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(N_STEPS - 1);

    acc_state_t       state_r;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] step_r;
    logic             part_ready_r;
    logic             done_r;
    logic [ACC_W-1:0] sum_s;
    logic             accept_s;

    overlap_adder_16x16 u_adder (
        .acc  (acc_r),
        .part (part_data),
        .step (step_r),
        .sum  (sum_s)
    );

    assign accept_s = part_valid && part_ready_r;

    // Control FSM, step counter and accumulator; start overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            acc_r        <= {ACC_W{1'b0}};
            step_r       <= {CNT_W{1'b0}};
            part_ready_r <= 1'b0;
            done_r       <= 1'b0;
        end else if (start) begin
            state_r      <= ACCUM;
            acc_r        <= {ACC_W{1'b0}};
            step_r       <= {CNT_W{1'b0}};
            part_ready_r <= 1'b1;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                ACCUM: begin
                    if (accept_s) begin
                        acc_r  <= sum_s;
                        // Wraps to zero on the last word.
                        step_r <= step_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (step_r == LAST_STEP) begin
                            state_r      <= DONE;
                            part_ready_r <= 1'b0;
                            done_r       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    part_ready_r <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign part_ready = part_ready_r;
    assign step       = step_r;
    assign acc        = acc_r;
    assign done       = done_r;

endmodule

// File: tb/tb_overlap_accumulator_16x16.sv
// Randomised self-checking bench for overlap_accumulator_16x16 against an
// arithmetic reference model (word k contributes part*2^k to the product).
module tb_overlap_accumulator_16x16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        part_valid;
    logic [15:0] part_data;
    logic        part_ready;
    logic [3:0]  step;
    logic [31:0] acc;
    logic        done;
    logic        done_ack;

    int checks   = 0;
    int failures = 0;

    // Reference model: running product, words taken, and phase
    logic [31:0] mdl_acc;
    int          mdl_words;
    bit          mdl_busy;
    bit          mdl_complete;

    overlap_accumulator_16x16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .part_valid (part_valid),
        .part_data  (part_data),
        .part_ready (part_ready),
        .step       (step),
        .acc        (acc),
        .done       (done),
        .done_ack   (done_ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_acc      = 32'd0;
        mdl_words    = 0;
        mdl_busy     = 1'b0;
        mdl_complete = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (start) begin
            mdl_acc      = 32'd0;
            mdl_words    = 0;
            mdl_busy     = 1'b1;
            mdl_complete = 1'b0;
        end else if (mdl_busy && part_valid) begin
            mdl_acc   = mdl_acc + (32'(part_data) * (32'd1 << mdl_words));
            mdl_words = mdl_words + 1;
            if (mdl_words == 16) begin
                mdl_busy     = 1'b0;
                mdl_complete = 1'b1;
            end
        end else if (mdl_complete && done_ack) begin
            mdl_complete = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_acc"},   acc,               mdl_acc);
        check_val({tag, "_step"},  32'(step),         32'(mdl_words % 16));
        check_val({tag, "_ready"}, 32'(part_ready),   32'(mdl_busy));
        check_val({tag, "_done"},  32'(done),         32'(mdl_complete));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        part_valid = 1'b0;
        part_data  = 16'd0;
        done_ack   = 1'b0;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick(tag);
        start = 1'b0;
    endtask

    // Feeds one word after up to max_gap idle cycles.
    task automatic feed(input logic [15:0] w, input int max_gap, input string tag);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            part_valid = 1'b0;
            part_data  = 16'($urandom);
            tick({tag, "_gap"});
        end
        part_valid = 1'b1;
        part_data  = w;
        tick(tag);
        part_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick(tag);
            n++;
        end
        check_val({tag, "_done_timeout"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        logic [31:0] prod;
        int          ack_delay;

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_all("rst");
        tick("rst_hold");
        rst_n = 1'b1;
        tick("post_rst");

        // 0x1234 * 3 with back-to-back words; done must appear after the 17th edge
        do_start("p1_start");
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_val("p1_done_c16", 32'(done), 32'd0);
            feed((i < 2) ? 16'h1234 : 16'h0000, 0, "p1");
        end
        check_val("p1_done_c17", 32'(done), 32'd1);
        check_val("p1_acc", acc, 32'h0000369C);

        // Valid words in DONE and IDLE are ignored
        part_valid = 1'b1;
        part_data  = 16'hFFFF;
        tick("ign_done");
        tick("ign_done");
        check_val("ign_done_acc", acc, 32'h0000369C);
        check_val("ign_done_ready", 32'(part_ready), 32'd0);
        done_ack = 1'b1;
        tick("ack");
        done_ack = 1'b0;
        tick("ign_idle");
        tick("ign_idle");
        check_val("ign_idle_acc", acc, 32'h0000369C);
        check_val("ign_idle_step", 32'(step), 32'd0);
        check_val("ign_idle_ready", 32'(part_ready), 32'd0);
        part_valid = 1'b0;

        // Maximum product with random gaps; step must run 0..15 then 0
        do_start("max_start");
        for (int i = 0; i < 16; i++) begin
            check_val("max_step_seq", 32'(step), 32'(i));
            feed(16'hFFFF, 3, "max");
        end
        check_val("max_acc", acc, 32'hFFFE0001);
        check_val("max_step_wrap", 32'(step), 32'd0);
        check_val("max_done", 32'(done), 32'd1);
        done_ack = 1'b1;
        tick("max_ack");
        done_ack = 1'b0;

        // Restart mid-product: start beats the concurrent word
        do_start("rs_start");
        for (int i = 0; i < 5; i++) feed(16'hFFFF, 0, "rs_pre");
        start      = 1'b1;
        part_valid = 1'b1;
        part_data  = 16'hFFFF;
        tick("rs_collide");
        start      = 1'b0;
        part_valid = 1'b0;
        check_val("rs_acc", acc, 32'd0);
        check_val("rs_step", 32'(step), 32'd0);
        check_val("rs_ready", 32'(part_ready), 32'd1);
        for (int i = 0; i < 16; i++) feed(16'h0001, 0, "rs_ones");
        check_val("rs_ones_acc", acc, 32'h0000FFFF);
        check_val("rs_ones_done", 32'(done), 32'd1);

        // Asynchronous reset while in DONE, asserted mid-cycle
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("arst_acc", acc, 32'd0);
        check_val("arst_step", 32'(step), 32'd0);
        check_val("arst_done", 32'(done), 32'd0);
        check_val("arst_ready", 32'(part_ready), 32'd0);
        tick("arst_hold");
        rst_n = 1'b1;
        tick("arst_rel");

        // done_ack together with start: start wins
        do_start("col_start");
        for (int i = 0; i < 16; i++) feed(16'($urandom), 1, "col");
        wait_done("col");
        start    = 1'b1;
        done_ack = 1'b1;
        tick("col_both");
        start    = 1'b0;
        done_ack = 1'b0;
        check_val("col_ready", 32'(part_ready), 32'd1);
        check_val("col_done", 32'(done), 32'd0);
        check_val("col_acc", acc, 32'd0);

        // Random products checked against a direct sum of shifted words
        for (int p = 0; p < 8; p++) begin
            if (p > 0) do_start("rnd_start");
            prod = 32'd0;
            for (int i = 0; i < 16; i++) begin
                w    = 16'($urandom);
                prod = prod + (32'(w) << i);
                feed(w, 2, "rnd");
            end
            wait_done("rnd");
            check_val("rnd_prod", acc, prod);
            ack_delay = int'($urandom_range(0, 3));
            for (int d = 0; d < ack_delay; d++) tick("rnd_wait");
            done_ack = 1'b1;
            tick("rnd_ack");
            done_ack = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
